// File: rtl/msg_comm_tx_ser.sv
// msg_comm_tx_ser: multi-lane serial message transmitter.
// Framed payload bytes arrive on a valid/ready stream, are queued in a FIFO
// and sent MSB-first over LANES data lanes with a bit clock, a frame sync
// and an optional CRC-8 trailer. Transmission starts once a whole frame is
// queued or the FIFO fills (cut-through for long frames).
//
// Handshake: a byte is transferred on every rising edge where
// s_valid && s_ready; s_data/s_last must be held stable while s_valid is
// high and s_ready is low. s_ready never depends on s_valid.
module msg_comm_tx_ser #(
  parameter int LANES      = 1,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CRC_EN     = 1,
  parameter int GAP_BITS   = 2
) (
  input  logic             phy_rx_clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             msg_clk_o,
  output logic             msg_fsx_o,
  output logic [LANES-1:0] msg_tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic [2:0]       dbg_state_o
);

  localparam int SLOTS    = 8 / LANES;
  localparam int SW       = $clog2(SLOTS) + 1;
  localparam int DW       = $clog2(CLK_DIV) + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int GW       = $clog2(GAP_BITS + 1) + 1;
  localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CRC   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // FIFO storage: {last, data}
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] frame_cnt;
  logic        full, empty, frame_rdy;
  logic [8:0]  rd_data;
  logic        acc, wr_en;

  // serialiser state
  logic [DW-1:0]    div_cnt;
  logic             clk_q;
  logic [SW-1:0]    slot_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       shreg, shreg_sh;
  logic             last_q;
  logic [7:0]       crc;
  logic             fsx_q;
  logic [LANES-1:0] tx_q;
  logic             done_q, under_q;
  logic             discard;
  logic             rdy_en;

  // FSM strobes
  logic pop, load_byte, load_crc, adv_slot, go_gap, done_nxt, abort;
  logic phase_end, slot_end, last_slot;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign frame_rdy = (frame_cnt != '0) || full;
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  // While discarding the tail of an aborted frame every byte is taken and dropped.
  assign s_ready = rdy_en && (discard || !full);
  assign acc     = s_valid && s_ready;
  assign wr_en   = acc && !discard && !abort;

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign slot_end  = clk_q && phase_end;
  assign last_slot = (slot_cnt == SW'(SLOTS - 1));
  assign shreg_sh  = shreg << LANES;

  assign msg_clk_o   = clk_q;
  assign msg_fsx_o   = fsx_q;
  assign msg_tx_o    = tx_q;
  assign busy_o      = (state != S_IDLE);
  assign done_o      = done_q;
  assign underrun_o  = under_q;
  assign dbg_state_o = state;

  // FSM state register
  always_ff @(posedge phy_rx_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and per-cycle datapath strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_byte = 1'b0;
    load_crc  = 1'b0;
    adv_slot  = 1'b0;
    go_gap    = 1'b0;
    done_nxt  = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: if (frame_rdy) state_nxt = S_LOAD;
      S_LOAD: begin
        pop       = 1'b1;
        load_byte = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: if (slot_end) begin
        if (!last_slot) adv_slot = 1'b1;
        else if (last_q) begin
          if (CRC_EN != 0) begin
            load_crc  = 1'b1;
            state_nxt = S_CRC;
          end else begin
            go_gap   = 1'b1;
            done_nxt = 1'b1;
          end
        end else if (!empty) begin
          pop       = 1'b1;
          load_byte = 1'b1;
        end else begin
          abort  = 1'b1;
          go_gap = 1'b1;
        end
      end
      S_CRC: if (slot_end) begin
        if (!last_slot) adv_slot = 1'b1;
        else begin
          go_gap   = 1'b1;
          done_nxt = 1'b1;
        end
      end
      S_GAP: if (slot_end && gap_cnt == GW'(GAP_LAST)) begin
        // a queued frame starts straight out of the gap so frames are
        // separated by exactly GAP_BITS bit periods
        if (frame_rdy) begin
          pop       = 1'b1;
          load_byte = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (go_gap) state_nxt = (GAP_BITS > 0) ? S_GAP : S_IDLE;
  end

  // FIFO storage write (no reset needed on the array)
  always_ff @(posedge phy_rx_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

  // FIFO pointers, complete-frame counter and discard flag
  always_ff @(posedge phy_rx_clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_cnt <= '0;
      discard   <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en && s_last, pop && rd_data[8]})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
      if (abort)                        discard <= !(acc && s_last);
      else if (discard && acc && s_last) discard <= 1'b0;
    end
  end

  // Bit clock divider, slot sequencing, shift register, CRC and line outputs
  always_ff @(posedge phy_rx_clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      clk_q    <= 1'b0;
      slot_cnt <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      crc      <= 8'hFF;
      fsx_q    <= 1'b0;
      tx_q     <= '0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      done_q  <= done_nxt;
      under_q <= abort;

      if (state == S_SHIFT || state == S_CRC || state == S_GAP) begin
        if (phase_end) begin
          div_cnt <= '0;
          clk_q   <= ~clk_q;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        clk_q   <= 1'b0;
      end

      if (state == S_IDLE) crc <= 8'hFF;

      if (load_byte) begin
        shreg    <= rd_data[7:0];
        last_q   <= rd_data[8];
        tx_q     <= rd_data[7 -: LANES];
        fsx_q    <= 1'b1;
        slot_cnt <= '0;
        crc      <= crc8_byte((state == S_SHIFT) ? crc : 8'hFF, rd_data[7:0]);
      end else if (load_crc) begin
        shreg    <= crc;
        tx_q     <= crc[7 -: LANES];
        slot_cnt <= '0;
      end else if (adv_slot) begin
        shreg    <= shreg_sh;
        tx_q     <= shreg_sh[7 -: LANES];
        slot_cnt <= slot_cnt + 1'b1;
      end else if (go_gap) begin
        fsx_q <= 1'b0;
        tx_q  <= '0;
      end

      if (go_gap)                          gap_cnt <= '0;
      else if (state == S_GAP && slot_end) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_msg_comm_tx_ser.sv
// Testbench for msg_comm_tx_ser: instance A is single-lane with CRC and a
// 4-entry FIFO, instance B is 4-lane without CRC. Line monitors rebuild
// the transmitted bytes; each scenario task checks its own results.
module tb_msg_comm_tx_ser;

  logic phy_rx_clk = 1'b0;
  logic rst_n      = 1'b0;

  logic [7:0] s_data_a = '0, s_data_b = '0;
  logic       s_valid_a = 1'b0, s_last_a = 1'b0, s_valid_b = 1'b0, s_last_b = 1'b0;
  logic       s_ready_a, s_ready_b;
  logic       msg_clk_a, msg_fsx_a, busy_a, done_a, under_a;
  logic       msg_clk_b, msg_fsx_b, busy_b, done_b, under_b;
  logic [0:0] msg_tx_a;
  logic [3:0] msg_tx_b;
  logic [2:0] dbg_a, dbg_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // clock / reset
  always #5 phy_rx_clk = ~phy_rx_clk;

  msg_comm_tx_ser #(.LANES(1), .CLK_DIV(2), .FIFO_DEPTH(4), .CRC_EN(1), .GAP_BITS(2)) u_a (
    .phy_rx_clk(phy_rx_clk), .rst_n(rst_n),
    .s_data(s_data_a), .s_valid(s_valid_a), .s_last(s_last_a), .s_ready(s_ready_a),
    .msg_clk_o(msg_clk_a), .msg_fsx_o(msg_fsx_a), .msg_tx_o(msg_tx_a),
    .busy_o(busy_a), .done_o(done_a), .underrun_o(under_a), .dbg_state_o(dbg_a)
  );

  msg_comm_tx_ser #(.LANES(4), .CLK_DIV(1), .FIFO_DEPTH(4), .CRC_EN(0), .GAP_BITS(2)) u_b (
    .phy_rx_clk(phy_rx_clk), .rst_n(rst_n),
    .s_data(s_data_b), .s_valid(s_valid_b), .s_last(s_last_b), .s_ready(s_ready_b),
    .msg_clk_o(msg_clk_b), .msg_fsx_o(msg_fsx_b), .msg_tx_o(msg_tx_b),
    .busy_o(busy_b), .done_o(done_b), .underrun_o(under_b), .dbg_state_o(dbg_b)
  );

  // line monitors
  int         cyc = 0;
  logic       clk_prev_a = 1'b0, fsx_prev_a = 1'b0, busy_prev_a = 1'b0;
  logic [6:0] sh_a = '0;
  int         bc_a = 0, rx_n_a = 0, fsx_cyc_a = 0, done_n_a = 0, under_n_a = 0;
  int         t_fall_a = 0, t_idle_a = 0, last_gap_a = 0, stall_n_a = 0;
  logic [7:0] rx_mem_a [256];

  always @(negedge phy_rx_clk) begin
    cyc         <= cyc + 1;
    clk_prev_a  <= msg_clk_a;
    fsx_prev_a  <= msg_fsx_a;
    busy_prev_a <= busy_a;
    if (!msg_fsx_a) bc_a <= 0;
    else if (msg_clk_a && !clk_prev_a) begin
      if (bc_a == 7) begin
        rx_mem_a[rx_n_a % 256] <= {sh_a, msg_tx_a[0]};
        rx_n_a <= rx_n_a + 1;
        bc_a   <= 0;
      end else begin
        sh_a <= {sh_a[5:0], msg_tx_a[0]};
        bc_a <= bc_a + 1;
      end
    end
    if (msg_fsx_a) fsx_cyc_a <= fsx_cyc_a + 1;
    if (done_a)    done_n_a  <= done_n_a + 1;
    if (under_a)   under_n_a <= under_n_a + 1;
    if (msg_fsx_a && !fsx_prev_a) last_gap_a <= cyc - t_fall_a;
    if (!msg_fsx_a && fsx_prev_a) t_fall_a <= cyc;
    if (!busy_a && busy_prev_a)   t_idle_a <= cyc;
    if (s_valid_a && !s_ready_a)  stall_n_a <= stall_n_a + 1;
  end

  logic       clk_prev_b = 1'b0;
  logic [3:0] nsh_b = '0;
  int         nc_b = 0, nib_n_b = 0, rx_n_b = 0, fsx_cyc_b = 0, done_n_b = 0;
  logic [3:0] nib_mem_b [256];
  logic [7:0] rx_mem_b [256];

  always @(negedge phy_rx_clk) begin
    clk_prev_b <= msg_clk_b;
    if (!msg_fsx_b) nc_b <= 0;
    else if (msg_clk_b && !clk_prev_b) begin
      nib_mem_b[nib_n_b % 256] <= msg_tx_b;
      nib_n_b <= nib_n_b + 1;
      if (nc_b == 1) begin
        rx_mem_b[rx_n_b % 256] <= {nsh_b, msg_tx_b};
        rx_n_b <= rx_n_b + 1;
        nc_b   <= 0;
      end else begin
        nsh_b <= msg_tx_b;
        nc_b  <= 1;
      end
    end
    if (msg_fsx_b) fsx_cyc_b <= fsx_cyc_b + 1;
    if (done_b)    done_n_b  <= done_n_b + 1;
  end

  // reference CRC-8 (poly 0x07, init 0xFF) over exp_q[from..], as a bit-serial LFSR
  function automatic logic [7:0] model_crc(input int from);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = from; i < exp_q.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ exp_q[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // driver tasks (entered and left on a falling edge)
  task automatic drive_a(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_data_a = d; s_last_a = l; s_valid_a = 1'b1;
    while (!s_ready_a && t < 2000) begin
      @(negedge phy_rx_clk);
      t++;
    end
    if (!s_ready_a) begin
      checks++; failures++;
      $display("FAIL drive_a_timeout byte=%h ready=%b required=1", d, s_ready_a);
    end
    @(negedge phy_rx_clk);
    s_valid_a = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_data_b = d; s_last_b = l; s_valid_b = 1'b1;
    while (!s_ready_b && t < 2000) begin
      @(negedge phy_rx_clk);
      t++;
    end
    if (!s_ready_b) begin
      checks++; failures++;
      $display("FAIL drive_b_timeout byte=%h ready=%b required=1", d, s_ready_b);
    end
    @(negedge phy_rx_clk);
    s_valid_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int t;
    t = 0;
    while (done_n_a < target && t < 5000) begin
      @(negedge phy_rx_clk);
      t++;
    end
    checks++;
    if (done_n_a < target) begin
      failures++;
      $display("FAIL done_wait got=%0d required=%0d", done_n_a, target);
    end
    t = 0;
    while (busy_a && t < 500) begin
      @(negedge phy_rx_clk);
      t++;
    end
    repeat (3) @(negedge phy_rx_clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge phy_rx_clk);
    checks++;
    if ({msg_clk_a, msg_fsx_a, msg_tx_a, busy_a, done_a, under_a, s_ready_a} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outs_a got=%b required=0",
               {msg_clk_a, msg_fsx_a, msg_tx_a, busy_a, done_a, under_a, s_ready_a});
    end
    checks++;
    if ({msg_clk_b, msg_fsx_b, msg_tx_b, busy_b, done_b, under_b, s_ready_b} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outs_b got=%b required=0",
               {msg_clk_b, msg_fsx_b, msg_tx_b, busy_b, done_b, under_b, s_ready_b});
    end
    rst_n = 1'b1;
    @(negedge phy_rx_clk);
    checks++;
    if (s_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_a got=%b required=1", s_ready_a);
    end
    checks++;
    if (s_ready_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_b got=%b required=1", s_ready_b);
    end
    repeat (3) @(negedge phy_rx_clk);
  endtask

  task automatic test_basic_frame();
    int s, f0, d0, u0;
    s = rx_n_a; f0 = fsx_cyc_a; d0 = done_n_a; u0 = under_n_a;
    exp_q = '{8'h01, 8'h02, 8'hCC};
    drive_a(8'h01, 1'b0);
    drive_a(8'h02, 1'b1);
    wait_done_a(d0 + 1);
    checks++;
    if (rx_n_a - s != 3) begin
      failures++;
      $display("FAIL basic_count got=%0d required=3", rx_n_a - s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem_a[(s + i) % 256] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h required=%h", i, rx_mem_a[(s + i) % 256], exp_q[i]);
      end
    end
    checks++;
    if (fsx_cyc_a - f0 != 96) begin
      failures++;
      $display("FAIL basic_fsx_cycles got=%0d required=96", fsx_cyc_a - f0);
    end
    checks++;
    if (done_n_a - d0 != 1 || under_n_a != u0) begin
      failures++;
      $display("FAIL basic_pulses done=%0d under=%0d required=1,0", done_n_a - d0, under_n_a - u0);
    end
    checks++;
    if (t_idle_a - t_fall_a != 8) begin
      failures++;
      $display("FAIL basic_gap_cycles got=%0d required=8", t_idle_a - t_fall_a);
    end
    checks++;
    if (msg_clk_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle clk=%b busy=%b required=0,0", msg_clk_a, busy_a);
    end
  endtask

  task automatic test_lanes4();
    int s, ns, f0, d0, t;
    s = rx_n_b; ns = nib_n_b; f0 = fsx_cyc_b; d0 = done_n_b;
    drive_b(8'hA5, 1'b1);
    t = 0;
    while ((done_n_b == d0 || busy_b) && t < 500) begin
      @(negedge phy_rx_clk);
      t++;
    end
    repeat (3) @(negedge phy_rx_clk);
    checks++;
    if (rx_n_b - s != 1 || rx_mem_b[s % 256] !== 8'hA5) begin
      failures++;
      $display("FAIL lanes4_byte count=%0d got=%h required=a5", rx_n_b - s, rx_mem_b[s % 256]);
    end
    checks++;
    if (nib_mem_b[ns % 256] !== 4'hA || nib_mem_b[(ns + 1) % 256] !== 4'h5) begin
      failures++;
      $display("FAIL lanes4_nibbles got=%h,%h required=a,5",
               nib_mem_b[ns % 256], nib_mem_b[(ns + 1) % 256]);
    end
    checks++;
    if (fsx_cyc_b - f0 != 4) begin
      failures++;
      $display("FAIL lanes4_fsx_cycles got=%0d required=4", fsx_cyc_b - f0);
    end
    checks++;
    if (done_n_b - d0 != 1) begin
      failures++;
      $display("FAIL lanes4_done got=%0d required=1", done_n_b - d0);
    end
  endtask

  task automatic test_cut_through();
    int s, f0, d0, u0, st0;
    s = rx_n_a; f0 = fsx_cyc_a; d0 = done_n_a; u0 = under_n_a; st0 = stall_n_a;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(model_crc(0));
    for (int i = 0; i < 10; i++) drive_a(exp_q[i], (i == 9));
    wait_done_a(d0 + 1);
    checks++;
    if (rx_n_a - s != 11) begin
      failures++;
      $display("FAIL cut_count got=%0d required=11", rx_n_a - s);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rx_mem_a[(s + i) % 256] !== exp_q[i]) begin
        failures++;
        $display("FAIL cut_byte%0d got=%h required=%h", i, rx_mem_a[(s + i) % 256], exp_q[i]);
      end
    end
    checks++;
    if (fsx_cyc_a - f0 != 352 || under_n_a != u0) begin
      failures++;
      $display("FAIL cut_contiguous fsx=%0d under=%0d required=352,0", fsx_cyc_a - f0, under_n_a - u0);
    end
    checks++;
    if (stall_n_a == st0) begin
      failures++;
      $display("FAIL cut_backpressure stalls=%0d required>0", stall_n_a - st0);
    end
  endtask

  task automatic test_underrun();
    int s, f0, d0, u0;
    s = rx_n_a; f0 = fsx_cyc_a; d0 = done_n_a; u0 = under_n_a;
    for (int i = 0; i < 5; i++) drive_a(8'h31 + 8'(i), 1'b0);
    repeat (300) @(negedge phy_rx_clk);
    checks++;
    if (under_n_a - u0 != 1 || done_n_a != d0) begin
      failures++;
      $display("FAIL underrun_pulse under=%0d done=%0d required=1,0", under_n_a - u0, done_n_a - d0);
    end
    drive_a(8'h36, 1'b0);
    drive_a(8'h37, 1'b0);
    drive_a(8'h38, 1'b1);
    exp_q = '{8'h41, 8'h42};
    exp_q.push_back(model_crc(0));
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, exp_q[0], exp_q[1], exp_q[2]};
    drive_a(8'h41, 1'b0);
    drive_a(8'h42, 1'b1);
    wait_done_a(d0 + 1);
    checks++;
    if (rx_n_a - s != 8) begin
      failures++;
      $display("FAIL underrun_count got=%0d required=8", rx_n_a - s);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_mem_a[(s + i) % 256] !== exp_q[i]) begin
        failures++;
        $display("FAIL underrun_byte%0d got=%h required=%h", i, rx_mem_a[(s + i) % 256], exp_q[i]);
      end
    end
    checks++;
    if (fsx_cyc_a - f0 != 256 || done_n_a - d0 != 1 || under_n_a - u0 != 1) begin
      failures++;
      $display("FAIL underrun_totals fsx=%0d done=%0d under=%0d required=256,1,1",
               fsx_cyc_a - f0, done_n_a - d0, under_n_a - u0);
    end
  endtask

  task automatic test_back_to_back();
    int s, d0;
    logic [7:0] c1;
    s = rx_n_a; d0 = done_n_a;
    exp_q = '{8'h51, 8'h52};
    c1 = model_crc(0);
    exp_q = '{8'h61, 8'h62};
    exp_q.push_back(model_crc(0));
    exp_q = '{8'h51, 8'h52, c1, exp_q[0], exp_q[1], exp_q[2]};
    drive_a(8'h51, 1'b0);
    drive_a(8'h52, 1'b1);
    drive_a(8'h61, 1'b0);
    drive_a(8'h62, 1'b1);
    wait_done_a(d0 + 2);
    checks++;
    if (done_n_a - d0 != 2) begin
      failures++;
      $display("FAIL b2b_done got=%0d required=2", done_n_a - d0);
    end
    checks++;
    if (last_gap_a != 8) begin
      failures++;
      $display("FAIL b2b_gap got=%0d required=8", last_gap_a);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_mem_a[(s + i) % 256] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d got=%h required=%h", i, rx_mem_a[(s + i) % 256], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, d0, u0, t;
    drive_a(8'h71, 1'b0);
    drive_a(8'h72, 1'b0);
    drive_a(8'h73, 1'b1);
    t = 0;
    while (!msg_fsx_a && t < 200) begin
      @(negedge phy_rx_clk);
      t++;
    end
    repeat (40) @(negedge phy_rx_clk);
    d0 = done_n_a; u0 = under_n_a;
    rst_n = 1'b0;
    @(negedge phy_rx_clk);
    rst_n = 1'b1;
    checks++;
    if ({msg_clk_a, msg_fsx_a, msg_tx_a, busy_a, done_a, under_a, s_ready_a} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_outs got=%b required=0",
               {msg_clk_a, msg_fsx_a, msg_tx_a, busy_a, done_a, under_a, s_ready_a});
    end
    repeat (20) @(negedge phy_rx_clk);
    checks++;
    if (busy_a !== 1'b0 || done_n_a != d0 || under_n_a != u0) begin
      failures++;
      $display("FAIL midreset_quiet busy=%b done=%0d under=%0d required=0,0,0",
               busy_a, done_n_a - d0, under_n_a - u0);
    end
    s = rx_n_a;
    exp_q = '{8'h81, 8'h82};
    exp_q.push_back(model_crc(0));
    drive_a(8'h81, 1'b0);
    drive_a(8'h82, 1'b1);
    wait_done_a(d0 + 1);
    checks++;
    if (rx_n_a - s != 3) begin
      failures++;
      $display("FAIL midreset_count got=%0d required=3", rx_n_a - s);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem_a[(s + i) % 256] !== exp_q[i]) begin
        failures++;
        $display("FAIL midreset_byte%0d got=%h required=%h", i, rx_mem_a[(s + i) % 256], exp_q[i]);
      end
    end
  endtask

  initial begin
    @(negedge phy_rx_clk);
    test_reset();
    test_basic_frame();
    test_lanes4();
    test_cut_through();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
